// File: rtl/stickman_physics_pkg.sv
// Shared types and shape extents for the stickman player and the color mapper.
package stickman_physics_pkg;

    typedef enum logic [1:0] {
        StGrounded = 2'd0,
        StRising   = 2'd1,
        StFalling  = 2'd2
    } jump_state_t;

    localparam logic [7:0] KeySpace = 8'h2C;

    // Sprite extents, relative to (X_POS, body top).
    localparam int BodyHalfW = 2;
    localparam int BodyBotY  = 9;
    localparam int LegTopY   = 10;
    localparam int LegBotY   = 18;
    localparam int Leg0Inner = 3;
    localparam int Leg0Outer = 5;
    localparam int Leg1Inner = 2;
    localparam int Leg1Outer = 4;

    function automatic logic in_range(int v, int lo, int hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/stickman_physics_if.sv
// Player-side bus: frame clock, key input, raster position in; hit flag and status out.
interface stickman_physics_if;
    logic       frame_clk;
    logic [7:0] keycode;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       is_stickman;
    logic [9:0] y_pos;
    logic       airborne;
    logic [1:0] state;

    modport master (
        output frame_clk, keycode, DrawX, DrawY,
        input  is_stickman, y_pos, airborne, state
    );

    modport slave (
        input  frame_clk, keycode, DrawX, DrawY,
        output is_stickman, y_pos, airborne, state
    );
endinterface

// File: rtl/stickman_physics_frame_tick_detect.sv
// Turns the slow frame clock level into a single-Clk tick on its rising edge.
module stickman_physics_frame_tick_detect (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic tick
);
    logic sync_q;
    logic prev_q;

    // Two-stage delay line; the edge is the compare between stages.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= frame_clk;
            prev_q <= sync_q;
        end
    end

    assign tick = sync_q & ~prev_q;
endmodule

// File: rtl/stickman_physics.sv
// Stickman player: vertical physics, jump FSM, leg animation and pixel hit test.
// Optional feature macro: DOUBLE_JUMP_EN (one extra jump while airborne).
module stickman_physics
    import stickman_physics_pkg::*;
#(
    parameter logic [9:0] X_POS    = 10'd200,
    parameter logic [9:0] FLOOR_Y  = 10'd300,
    parameter logic [9:0] CEIL_Y   = 10'd10,
    parameter logic [9:0] JUMP_V   = 10'd12,
    parameter logic [9:0] GRAVITY  = 10'd1,
    parameter logic [9:0] MAX_FALL = 10'd12,
    parameter logic [7:0] JUMP_KEY = KeySpace,
    parameter logic [3:0] ANIM_DIV = 4'd8
) (
    input  logic                Clk,
    input  logic                Reset,
    stickman_physics_if.slave   bus
);
    logic        tick;
    jump_state_t state_q, state_d;
    logic [9:0]  pos_q, pos_d;
    logic [9:0]  vel_q, vel_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        phase_q, phase_d;
    logic        jump_req_q, jump_req_d;
    logic [7:0]  key_prev_q;
    logic        press;
    logic        air_jump;
`ifdef DOUBLE_JUMP_EN
    logic        credit_q, credit_d;
`endif

    logic signed [10:0] pos_s, sum_s, ceil_s, floor_s;
    logic [9:0]         vel_inc, fall_vel, pos_clamped, jump_vel;

    stickman_physics_frame_tick_detect u_tick (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (bus.frame_clk),
        .tick      (tick)
    );

    assign press    = (bus.keycode == JUMP_KEY) && (key_prev_q != JUMP_KEY);
    assign jump_vel = 10'd0 - JUMP_V;
`ifdef DOUBLE_JUMP_EN
    assign air_jump = jump_req_q & credit_q;
`else
    assign air_jump = 1'b0;
`endif

    // Signed position arithmetic and clamping to the playable band.
    always_comb begin
        pos_s    = signed'({1'b0, pos_q});
        sum_s    = pos_s + signed'({vel_q[9], vel_q});
        ceil_s   = signed'({1'b0, CEIL_Y});
        floor_s  = signed'({1'b0, FLOOR_Y});
        vel_inc  = vel_q + GRAVITY;
        fall_vel = (signed'(vel_inc) > signed'(MAX_FALL)) ? MAX_FALL : vel_inc;
        if (sum_s < ceil_s) begin
            pos_clamped = CEIL_Y;
        end else if (sum_s > floor_s) begin
            pos_clamped = FLOOR_Y;
        end else begin
            pos_clamped = sum_s[9:0];
        end
    end

    // Jump FSM, physics and animation next-state; everything advances only on tick.
    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        vel_d      = vel_q;
        cnt_d      = cnt_q;
        phase_d    = phase_q;
        jump_req_d = jump_req_q;
`ifdef DOUBLE_JUMP_EN
        credit_d   = credit_q;
`endif
        // A request never survives the tick that sees it.
        if (tick) begin
            jump_req_d = 1'b0;
        end
        if (press) begin
            jump_req_d = 1'b1;
        end

        if (tick) begin
            unique case (state_q)
                StGrounded: begin
                    if (cnt_q == ANIM_DIV - 4'd1) begin
                        cnt_d   = 4'd0;
                        phase_d = ~phase_q;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                    if (jump_req_q) begin
                        vel_d   = jump_vel;
                        state_d = StRising;
                    end else begin
                        vel_d = 10'd0;
                        pos_d = FLOOR_Y;
                    end
                end
                StRising: begin
                    if (air_jump) begin
                        vel_d = jump_vel;
`ifdef DOUBLE_JUMP_EN
                        credit_d = 1'b0;
`endif
                    end else if (sum_s <= ceil_s) begin
                        pos_d   = CEIL_Y;
                        vel_d   = 10'd0;
                        state_d = StFalling;
                    end else begin
                        pos_d = pos_clamped;
                        vel_d = vel_inc;
                        if (!vel_inc[9]) begin
                            state_d = StFalling;
                        end
                    end
                end
                StFalling: begin
                    // Landing takes priority over any pending request.
                    if (sum_s >= floor_s) begin
                        pos_d   = FLOOR_Y;
                        vel_d   = 10'd0;
                        state_d = StGrounded;
`ifdef DOUBLE_JUMP_EN
                        credit_d = 1'b1;
`endif
                    end else if (air_jump) begin
                        vel_d   = jump_vel;
                        state_d = StRising;
`ifdef DOUBLE_JUMP_EN
                        credit_d = 1'b0;
`endif
                    end else begin
                        pos_d = pos_clamped;
                        vel_d = fall_vel;
                    end
                end
                default: begin
                    state_d = StGrounded;
                    pos_d   = FLOOR_Y;
                    vel_d   = 10'd0;
                end
            endcase
        end
    end

    // State registers; reset dominates tick.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= StGrounded;
            pos_q      <= FLOOR_Y;
            vel_q      <= 10'd0;
            cnt_q      <= 4'd0;
            phase_q    <= 1'b0;
            jump_req_q <= 1'b0;
            key_prev_q <= 8'd0;
`ifdef DOUBLE_JUMP_EN
            credit_q   <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            vel_q      <= vel_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            jump_req_q <= jump_req_d;
            key_prev_q <= bus.keycode;
`ifdef DOUBLE_JUMP_EN
            credit_q   <= credit_d;
`endif
        end
    end

    // Pixel hit test; legs are drawn together while airborne.
    always_comb begin
        logic signed [10:0] rx;
        logic signed [10:0] ry;
        logic               leg_phase;
        logic               body;
        logic               legs;
        rx        = signed'({1'b0, bus.DrawX}) - signed'({1'b0, X_POS});
        ry        = signed'({1'b0, bus.DrawY}) - signed'({1'b0, pos_q});
        leg_phase = (state_q == StGrounded) ? phase_q : 1'b0;
        body      = in_range(int'(rx), -BodyHalfW, BodyHalfW) && in_range(int'(ry), 0, BodyBotY);
        if (!in_range(int'(ry), LegTopY, LegBotY)) begin
            legs = 1'b0;
        end else if (leg_phase) begin
            legs = in_range(int'(rx), -Leg1Outer, -Leg1Inner) ||
                   in_range(int'(rx), Leg1Inner, Leg1Outer);
        end else begin
            legs = in_range(int'(rx), -Leg0Outer, -Leg0Inner) ||
                   in_range(int'(rx), Leg0Inner, Leg0Outer);
        end
        bus.is_stickman = body | legs;
    end

    assign bus.y_pos    = pos_q;
    assign bus.airborne = (state_q != StGrounded);
    assign bus.state    = state_q;
endmodule

// File: tb/tb_stickman_physics.sv
// Bench for stickman_physics: default instance plus a low-ceiling (CEIL_Y=250) instance,
// both checked per frame against a reference model through a scoreboard queue.
module tb_stickman_physics;
`ifdef DOUBLE_JUMP_EN
    localparam bit DJ = 1'b1;
`else
    localparam bit DJ = 1'b0;
`endif

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    stickman_physics_if bus_a ();
    stickman_physics_if bus_c ();

    stickman_physics dut_a (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus_a)
    );

    stickman_physics #(.CEIL_Y(10'd250)) dut_c (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus_c)
    );

    typedef struct {
        int y; int v; int st; int credit; int jreq; int phase; int cnt;
    } mdl_t;
    typedef struct { int y; int st; } exp_t;

    int    n_tests = 0;
    int    n_fail  = 0;
    mdl_t  ma, mc;
    exp_t  sb_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.y = 300; m.v = 0; m.st = 0; m.credit = 1; m.jreq = 0; m.phase = 0; m.cnt = 0;
        return m;
    endfunction

    function automatic mdl_t mdl_step(input mdl_t m, input int ceil);
        mdl_t r;
        int np, nv;
        r  = m;
        np = m.y + m.v;
        if (m.st == 0) begin
            r.cnt = m.cnt + 1;
            if (r.cnt == 8) begin
                r.cnt = 0;
                r.phase = 1 - m.phase;
            end
            if (m.jreq != 0) begin
                r.v = -12; r.st = 1;
            end else begin
                r.v = 0; r.y = 300;
            end
        end else if (m.st == 1) begin
            nv = m.v + 1;
            if (DJ && m.jreq != 0 && m.credit != 0) begin
                r.v = -12; r.credit = 0;
            end else if (np <= ceil) begin
                r.y = ceil; r.v = 0; r.st = 2;
            end else begin
                r.y = np; r.v = nv;
                if (nv >= 0) r.st = 2;
            end
        end else begin
            nv = (m.v + 1 > 12) ? 12 : m.v + 1;
            if (np >= 300) begin
                r.y = 300; r.v = 0; r.st = 0; r.credit = 1;
            end else if (DJ && m.jreq != 0 && m.credit != 0) begin
                r.v = -12; r.st = 1; r.credit = 0;
            end else begin
                r.y = np; r.v = nv;
            end
        end
        r.jreq = 0;
        return r;
    endfunction

    // One frame_clk pulse; expectations queued before, compared after it settles.
    task automatic frame();
        exp_t e;
        ma = mdl_step(ma, 10);
        mc = mdl_step(mc, 250);
        sb_q.push_back('{ma.y, ma.st});
        sb_q.push_back('{mc.y, mc.st});
        @(negedge Clk);
        bus_a.frame_clk = 1'b1; bus_c.frame_clk = 1'b1;
        repeat (3) @(negedge Clk);
        bus_a.frame_clk = 1'b0; bus_c.frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
        e = sb_q.pop_front();
        check_eq("a_y_pos", 32'(bus_a.y_pos), e.y);
        check_eq("a_state", 32'(bus_a.state), e.st);
        check_eq("a_airborne", 32'(bus_a.airborne), 32'(e.st != 0));
        e = sb_q.pop_front();
        check_eq("c_y_pos", 32'(bus_c.y_pos), e.y);
        check_eq("c_state", 32'(bus_c.state), e.st);
    endtask

    task automatic set_key(input logic [7:0] k);
        bus_a.keycode = k; bus_c.keycode = k;
    endtask

    task automatic press();
        @(negedge Clk); set_key(8'h00);
        @(negedge Clk); set_key(8'h2C);
        @(negedge Clk);
        ma.jreq = 1; mc.jreq = 1;
    endtask

    task automatic pix(input string tag, input int x, input int y, input bit exp);
        bus_a.DrawX = 10'(x); bus_a.DrawY = 10'(y);
        #1;
        check_eq(tag, 32'(bus_a.is_stickman), 32'(exp));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        ma = mdl_reset(); mc = mdl_reset();
        bus_a.frame_clk = 1'b0; bus_c.frame_clk = 1'b0;
        set_key(8'h00);
        bus_a.DrawX = 10'd200; bus_a.DrawY = 10'd300;
        bus_c.DrawX = 10'd0;   bus_c.DrawY = 10'd0;

        // Reset state
        repeat (2) @(posedge Clk);
        #1;
        check_eq("rst_y_pos", 32'(bus_a.y_pos), 300);
        check_eq("rst_state", 32'(bus_a.state), 0);
        check_eq("rst_airborne", 32'(bus_a.airborne), 0);
        pix("rst_pix_top", 200, 300, 1'b1);
        pix("rst_pix_above", 200, 299, 1'b0);
        pix("rst_pix_body_edge", 202, 309, 1'b1);
        pix("rst_pix_body_out", 203, 305, 1'b0);
        @(negedge Clk); Reset = 1'b0;

        // Grounded leg animation over 16 ticks
        for (int i = 1; i <= 16; i++) begin
            frame();
            pix("anim_205_315", 205, 315, ma.phase == 0);
            pix("anim_202_315", 202, 315, ma.phase == 1);
            pix("anim_204_315", 204, 315, 1'b1);
            pix("anim_below_legs", 204, 319, 1'b0);
        end
        check_eq("anim_phase_back", 32'(ma.phase), 0);

        // Jump with SPACE held: apex, landing, no repeat; low-ceiling clamp on dut_c
        press();
        for (int i = 1; i <= 32; i++) begin
            frame();
            if (i == 1) check_eq("jump_t1_state", 32'(bus_a.state), 1);
            if (i == 6) begin
                check_eq("ceil_clamp_y", 32'(bus_c.y_pos), 250);
                check_eq("ceil_clamp_state", 32'(bus_c.state), 2);
            end
            if (i == 13) begin
                check_eq("apex_y", 32'(bus_a.y_pos), 222);
                check_eq("apex_state", 32'(bus_a.state), 2);
                pix("air_legs_205", 205, 237, 1'b1);
                pix("air_legs_202", 202, 237, 1'b0);
            end
            if (i == 26) begin
                check_eq("land_y", 32'(bus_a.y_pos), 300);
                check_eq("land_state", 32'(bus_a.state), 0);
            end
            if (i == 32) check_eq("hold_no_rejump", 32'(bus_a.state), 0);
        end

        // Second press while falling, third press ignored until landed
        press();
        guard = 0;
        while (ma.st != 2 && guard < 40) begin
            frame();
            guard++;
        end
        check_eq("dj_reach_falling", 32'(bus_a.state), 2);
        press();
        frame();
        check_eq("dj_second_press_state", 32'(bus_a.state), DJ ? 1 : 2);
        press();
        frame();
        check_eq("dj_third_press_state", 32'(bus_a.state), DJ ? 1 : 2);
        guard = 0;
        while (ma.st != 0 && guard < 80) begin
            frame();
            guard++;
        end
        check_eq("dj_landed", 32'(bus_a.state), 0);

        // Reset mid-jump with a request pending
        press();
        guard = 0;
        while (!(ma.st == 1 && ma.y <= 250) && guard < 20) begin
            frame();
            guard++;
        end
        check_eq("mid_jump_airborne", 32'(bus_a.airborne), 1);
        press();
        @(negedge Clk);
        Reset = 1'b1;
        set_key(8'h00);
        @(posedge Clk);
        #1;
        check_eq("midrst_y_pos", 32'(bus_a.y_pos), 300);
        check_eq("midrst_state", 32'(bus_a.state), 0);
        check_eq("midrst_c_y_pos", 32'(bus_c.y_pos), 300);
        ma = mdl_reset(); mc = mdl_reset();
        @(negedge Clk); Reset = 1'b0;
        frame();
        check_eq("midrst_no_jump", 32'(bus_a.state), 0);
        frame();
        check_eq("sb_drained", 32'(sb_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
